// File: rtl/banco_registros_pkg.sv
// Shared constants for the datapath register file (banco_registros).
// Default geometry is 32 registers of 32 bits; register 0 is hard-wired to zero.
package banco_registros_pkg;

    localparam int ANCHO_DATO_DEF = 32;
    localparam int ANCHO_DIR_DEF  = 5;
    localparam int NUM_REGS       = 2 ** ANCHO_DIR_DEF;

    localparam logic [ANCHO_DIR_DEF-1:0] REG_CERO = 5'd0;

endpackage : banco_registros_pkg

// File: rtl/banco_registros_lectura_puerto.sv
// One combinational read port of the register file.
// It decodes the read address against the stored entries 1..N-1, and forces
// address 0 (and any address that matches no entry) to zero.  When bypass_en
// is high and the read address equals the address being written, the
// incoming write data is returned instead of the stored value.  The top level
// holds bypass_en low unless it is built with BANCO_REG_BYPASS_EN.
module lectura_puerto
    import banco_registros_pkg::*;
#(
    parameter int ANCHO_DATO = ANCHO_DATO_DEF,
    parameter int ANCHO_DIR  = ANCHO_DIR_DEF
) (
    input  logic [2**ANCHO_DIR-1:1][ANCHO_DATO-1:0] almacen,
    input  logic [ANCHO_DIR-1:0]                    dir_lectura,
    input  logic                                    bypass_en,
    input  logic [ANCHO_DIR-1:0]                    dir_escritura,
    input  logic [ANCHO_DATO-1:0]                   dato_escritura,
    output logic [ANCHO_DATO-1:0]                   dato_lectura
);

    localparam int NUM_ENTRADAS = 2 ** ANCHO_DIR;

    logic [ANCHO_DATO-1:0] leido_s;
    logic                  coincide_s;

    // Address decode over the stored entries; no match (address 0) yields zero.
    always_comb begin
        leido_s = '0;
        for (int i = 1; i < NUM_ENTRADAS; i++) begin
            leido_s = (dir_lectura == ANCHO_DIR'(i)) ? almacen[i] : leido_s;
        end
    end

    // Bypass hit: same address as the write in flight, never for register 0.
    always_comb begin
        coincide_s = 1'b0;
        if (bypass_en && (dir_lectura == dir_escritura) &&
            (dir_lectura != ANCHO_DIR'(REG_CERO))) begin
            coincide_s = 1'b1;
        end else begin
            coincide_s = 1'b0;
        end
    end

    // Output select between the stored value and the write-through data.
    always_comb begin
        dato_lectura = '0;
        if (coincide_s) begin
            dato_lectura = dato_escritura;
        end else begin
            dato_lectura = leido_s;
        end
    end

endmodule : lectura_puerto

// File: rtl/banco_registros.sv
// banco_registros: 32 x 32-bit register file for the single-cycle datapath.
// Two combinational read ports (rs, rt), one synchronous write port.
// Register 0 always reads zero and has no storage.
// Optional macro BANCO_REG_BYPASS_EN: when defined, a read of the register
// being written in the same cycle returns the new write data combinationally;
// when undefined, such a read returns the old value until the clock edge.
module banco_registros
    import banco_registros_pkg::*;
#(
    parameter int ANCHO_DATO = ANCHO_DATO_DEF,
    parameter int ANCHO_DIR  = ANCHO_DIR_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Escritura_En,
    input  logic [ANCHO_DIR-1:0]  Dir_Escritura,
    input  logic [ANCHO_DATO-1:0] Dato_Escritura,
    input  logic [ANCHO_DIR-1:0]  Dir_Lectura_1,
    input  logic [ANCHO_DIR-1:0]  Dir_Lectura_2,
    output logic [ANCHO_DATO-1:0] Dato_Lectura_1,
    output logic [ANCHO_DATO-1:0] Dato_Lectura_2
);

    localparam int NUM_ENTRADAS = 2 ** ANCHO_DIR;

    // Entries 1..N-1 only; entry 0 is implied zero.
    logic [NUM_ENTRADAS-1:1][ANCHO_DATO-1:0] regs_r;
    logic                                    escritura_valida_s;
    logic                                    bypass_en_s;

    // Qualify the write: enabled and not aimed at register 0.
    always_comb begin
        escritura_valida_s = 1'b0;
        if (Escritura_En && (Dir_Escritura != ANCHO_DIR'(REG_CERO))) begin
            escritura_valida_s = 1'b1;
        end else begin
            escritura_valida_s = 1'b0;
        end
    end

    // Bypass is only meaningful for a write that will actually land this edge.
    always_comb begin
        bypass_en_s = 1'b0;
`ifdef BANCO_REG_BYPASS_EN
        if (escritura_valida_s && !Reset) begin
            bypass_en_s = 1'b1;
        end else begin
            bypass_en_s = 1'b0;
        end
`else
        bypass_en_s = 1'b0;
`endif
    end

    // Storage update: reset clears everything and overrides any write.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            regs_r <= '0;
        end else if (escritura_valida_s) begin
            for (int i = 1; i < NUM_ENTRADAS; i++) begin
                if (Dir_Escritura == ANCHO_DIR'(i)) begin
                    regs_r[i] <= Dato_Escritura;
                end
            end
        end
    end

    lectura_puerto #(
        .ANCHO_DATO (ANCHO_DATO),
        .ANCHO_DIR  (ANCHO_DIR)
    ) u_lectura_1 (
        .almacen        (regs_r),
        .dir_lectura    (Dir_Lectura_1),
        .bypass_en      (bypass_en_s),
        .dir_escritura  (Dir_Escritura),
        .dato_escritura (Dato_Escritura),
        .dato_lectura   (Dato_Lectura_1)
    );

    lectura_puerto #(
        .ANCHO_DATO (ANCHO_DATO),
        .ANCHO_DIR  (ANCHO_DIR)
    ) u_lectura_2 (
        .almacen        (regs_r),
        .dir_lectura    (Dir_Lectura_2),
        .bypass_en      (bypass_en_s),
        .dir_escritura  (Dir_Escritura),
        .dato_escritura (Dato_Escritura),
        .dato_lectura   (Dato_Lectura_2)
    );

endmodule : banco_registros

// File: tb/tb_banco_registros.sv
// Directed self-checking bench for banco_registros.
// Inputs are driven on the falling edge; outputs are sampled #1 after a
// rising edge or #1 after the falling-edge drive (reads are combinational).
module tb_banco_registros;

    logic        Clk;
    logic        Reset;
    logic        Escritura_En;
    logic [4:0]  Dir_Escritura;
    logic [31:0] Dato_Escritura;
    logic [4:0]  Dir_Lectura_1;
    logic [4:0]  Dir_Lectura_2;
    logic [31:0] Dato_Lectura_1;
    logic [31:0] Dato_Lectura_2;

    int checks;
    int errors;

    banco_registros dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Escritura_En   (Escritura_En),
        .Dir_Escritura  (Dir_Escritura),
        .Dato_Escritura (Dato_Escritura),
        .Dir_Lectura_1  (Dir_Lectura_1),
        .Dir_Lectura_2  (Dir_Lectura_2),
        .Dato_Lectura_1 (Dato_Lectura_1),
        .Dato_Lectura_2 (Dato_Lectura_2)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Stimulus helper: present one write for exactly one rising edge.
    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        @(negedge Clk);
        Escritura_En   = 1'b1;
        Dir_Escritura  = addr;
        Dato_Escritura = data;
        @(posedge Clk);
        #1;
        Escritura_En   = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        Reset          = 1'b1;
        Escritura_En   = 1'b1;
        Dir_Escritura  = 5'd9;
        Dato_Escritura = 32'h5555_AAAA;
        @(posedge Clk);
        #1;
        Reset        = 1'b0;
        Escritura_En = 1'b0;
        for (int a = 0; a < 32; a++) begin
            @(negedge Clk);
            Dir_Lectura_1 = 5'(a);
            Dir_Lectura_2 = 5'(31 - a);
            #1;
            checks++;
            if (Dato_Lectura_1 !== 32'h0) begin
                errors++;
                $display("FAIL reset_p1 addr=%0d got=%h exp=%h", a, Dato_Lectura_1, 32'h0);
            end
            checks++;
            if (Dato_Lectura_2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_p2 addr=%0d got=%h exp=%h", 31 - a, Dato_Lectura_2, 32'h0);
            end
        end
    endtask

    task automatic test_write();
        do_write(5'd5, 32'hDEAD_BEEF);
        @(negedge Clk);
        Dir_Lectura_1 = 5'd5;
        Dir_Lectura_2 = 5'd6;
        #1;
        checks++;
        if (Dato_Lectura_1 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_addr5 got=%h exp=%h", Dato_Lectura_1, 32'hDEAD_BEEF);
        end
        checks++;
        if (Dato_Lectura_2 !== 32'h0) begin
            errors++;
            $display("FAIL write_addr6 got=%h exp=%h", Dato_Lectura_2, 32'h0);
        end
        // Swap ports to confirm port 2 sees the same entry.
        Dir_Lectura_1 = 5'd6;
        Dir_Lectura_2 = 5'd5;
        #1;
        checks++;
        if (Dato_Lectura_2 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_addr5_p2 got=%h exp=%h", Dato_Lectura_2, 32'hDEAD_BEEF);
        end
        checks++;
        if (Dato_Lectura_1 !== 32'h0) begin
            errors++;
            $display("FAIL write_addr6_p1 got=%h exp=%h", Dato_Lectura_1, 32'h0);
        end
    endtask

    task automatic test_write_zero();
        do_write(5'd0, 32'hFFFF_FFFF);
        @(negedge Clk);
        Dir_Lectura_1 = 5'd0;
        Dir_Lectura_2 = 5'd0;
        #1;
        checks++;
        if (Dato_Lectura_1 !== 32'h0) begin
            errors++;
            $display("FAIL zero_p1 got=%h exp=%h", Dato_Lectura_1, 32'h0);
        end
        checks++;
        if (Dato_Lectura_2 !== 32'h0) begin
            errors++;
            $display("FAIL zero_p2 got=%h exp=%h", Dato_Lectura_2, 32'h0);
        end
        // Register 5 must be untouched by the ignored write.
        Dir_Lectura_1 = 5'd5;
        #1;
        checks++;
        if (Dato_Lectura_1 !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL zero_keeps5 got=%h exp=%h", Dato_Lectura_1, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_write_disable();
        @(negedge Clk);
        Escritura_En   = 1'b0;
        Dir_Escritura  = 5'd7;
        Dato_Escritura = 32'h1234_5678;
        @(posedge Clk);
        #1;
        @(negedge Clk);
        Dir_Lectura_1 = 5'd7;
        Dir_Lectura_2 = 5'd7;
        #1;
        checks++;
        if (Dato_Lectura_1 !== 32'h0) begin
            errors++;
            $display("FAIL disable_p1 got=%h exp=%h", Dato_Lectura_1, 32'h0);
        end
        checks++;
        if (Dato_Lectura_2 !== 32'h0) begin
            errors++;
            $display("FAIL disable_p2 got=%h exp=%h", Dato_Lectura_2, 32'h0);
        end
    endtask

    task automatic test_same_addr();
        logic [31:0] exp_antes;
`ifdef BANCO_REG_BYPASS_EN
        exp_antes = 32'hB;
`else
        exp_antes = 32'hA;
`endif
        do_write(5'd31, 32'hA);
        @(negedge Clk);
        Escritura_En   = 1'b1;
        Dir_Escritura  = 5'd31;
        Dato_Escritura = 32'hB;
        Dir_Lectura_1  = 5'd31;
        Dir_Lectura_2  = 5'd31;
        #1;
        checks++;
        if (Dato_Lectura_1 !== exp_antes) begin
            errors++;
            $display("FAIL same_before_p1 got=%h exp=%h", Dato_Lectura_1, exp_antes);
        end
        checks++;
        if (Dato_Lectura_2 !== exp_antes) begin
            errors++;
            $display("FAIL same_before_p2 got=%h exp=%h", Dato_Lectura_2, exp_antes);
        end
        @(posedge Clk);
        #1;
        Escritura_En = 1'b0;
        #1;
        checks++;
        if (Dato_Lectura_1 !== 32'hB) begin
            errors++;
            $display("FAIL same_after_p1 got=%h exp=%h", Dato_Lectura_1, 32'hB);
        end
        checks++;
        if (Dato_Lectura_2 !== 32'hB) begin
            errors++;
            $display("FAIL same_after_p2 got=%h exp=%h", Dato_Lectura_2, 32'hB);
        end
    endtask

    task automatic test_reset_mid();
        for (int a = 1; a < 32; a++) begin
            do_write(5'(a), 32'(a));
        end
        // Changing read addresses with no write must not disturb contents.
        @(negedge Clk);
        Dir_Lectura_1 = 5'd17;
        Dir_Lectura_2 = 5'd2;
        @(posedge Clk);
        #1;
        for (int a = 0; a < 32; a++) begin
            @(negedge Clk);
            Dir_Lectura_1 = 5'(a);
            Dir_Lectura_2 = 5'(a);
            #1;
            checks++;
            if (Dato_Lectura_1 !== 32'(a)) begin
                errors++;
                $display("FAIL fill_p1 addr=%0d got=%h exp=%h", a, Dato_Lectura_1, 32'(a));
            end
            checks++;
            if (Dato_Lectura_2 !== 32'(a)) begin
                errors++;
                $display("FAIL fill_p2 addr=%0d got=%h exp=%h", a, Dato_Lectura_2, 32'(a));
            end
        end
        @(negedge Clk);
        Reset          = 1'b1;
        Escritura_En   = 1'b1;
        Dir_Escritura  = 5'd3;
        Dato_Escritura = 32'hCAFE_0003;
        @(posedge Clk);
        #1;
        Reset        = 1'b0;
        Escritura_En = 1'b0;
        for (int a = 0; a < 32; a++) begin
            @(negedge Clk);
            Dir_Lectura_1 = 5'(a);
            Dir_Lectura_2 = 5'(31 - a);
            #1;
            checks++;
            if (Dato_Lectura_1 !== 32'h0) begin
                errors++;
                $display("FAIL midreset_p1 addr=%0d got=%h exp=%h", a, Dato_Lectura_1, 32'h0);
            end
            checks++;
            if (Dato_Lectura_2 !== 32'h0) begin
                errors++;
                $display("FAIL midreset_p2 addr=%0d got=%h exp=%h", 31 - a, Dato_Lectura_2, 32'h0);
            end
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        Reset          = 1'b1;
        Escritura_En   = 1'b0;
        Dir_Escritura  = 5'd0;
        Dato_Escritura = 32'h0;
        Dir_Lectura_1  = 5'd0;
        Dir_Lectura_2  = 5'd0;

        test_reset();
        test_write();
        test_write_zero();
        test_write_disable();
        test_same_addr();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_banco_registros
